id_ex_stage: RTL and testbench

ID/EX pipeline stage sitting directly upstream of the integer ALU in the 5-stage RV32I core. It registers the decoded operands and control from decode, and detects load-use hazards. It applies EX/MEM and MEM/WB operand forwarding and drives the ALU's SrcA, SrcB and ALUControl inputs, plus the side-band control consumed by EX/MEM.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/forward_unit.sv | 36 +++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: ALU opcodes, forwarding selects, EX control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_BLT   = 4'b0101;
    localparam logic [3:0] ALU_BLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_BGE   = 4'b1001;
    localparam logic [3:0] ALU_BGEU  = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_BNE   = 4'b1100;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    // Operand source chosen by the forwarding unit.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Side-band control carried from decode into EX and on to EX/MEM.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Picks the freshest source for each EX operand from EX/MEM, MEM/WB or the register copy.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output fwd_sel_e              fwd_a,
    output fwd_sel_e              fwd_b
);

    logic mem_live;
    logic wb_live;

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    assign mem_live = mem_reg_write && (mem_rd != '0);
    assign wb_live  = wb_reg_write  && (wb_rd  != '0);

    // EX/MEM is younger than MEM/WB, so it wins when both hit.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (mem_live && (mem_rd == rs1))     fwd_a = FWD_MEM;
        else if (wb_live && (wb_rd == rs1))  fwd_a = FWD_WB;
        if (mem_live && (mem_rd == rs2))     fwd_b = FWD_MEM;
        else if (wb_live && (wb_rd == rs2))  fwd_b = FWD_WB;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register: captures decode, detects load-use, forwards operands into the ALU.
// Latency: decode fields appear on EX outputs one cycle after capture; forwarding is combinational.
// Backpressure: stall_i holds every EX register; load-use inserts a bubble while decode is held upstream.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  id_valid,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rd1,
    input  logic [DATA_WIDTH-1:0] id_rd2,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_control,
    input  logic                  id_alu_src_a,
    input  logic                  id_alu_src_b,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  load_use_hazard,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] SrcA,
    output logic [DATA_WIDTH-1:0] SrcB,
    output logic [3:0]            ALUControl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_jump
);

    logic                  valid_q;
    ex_ctrl_t              ctrl_q;
    ex_ctrl_t              id_ctrl;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic [DATA_WIDTH-1:0] rd2_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [3:0]            alu_ctrl_q;
    logic                  src_a_pc_q;
    logic                  src_b_imm_q;
    logic [DATA_WIDTH-1:0] rd1_cap;
    logic [DATA_WIDTH-1:0] rd2_cap;
    logic [DATA_WIDTH-1:0] fwd_a_dat;
    logic [DATA_WIDTH-1:0] fwd_b_dat;
    fwd_sel_e              fwd_a;
    fwd_sel_e              fwd_b;

    assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read,
                       mem_write: id_mem_write, branch: id_branch, jump: id_jump};

    // Conservative: both rs fields are compared whatever the decoded format.
    assign load_use_hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                             ((rd_q == id_rs1) || (rd_q == id_rs2));

    // The regfile writes at the same edge we capture, so pick up the WB value directly.
    assign rd1_cap = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_result : id_rd1;
    assign rd2_cap = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_result : id_rd2;

    // EX register: flush beats stall beats load-use bubble beats normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_ctrl_q  <= ALU_ADD;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (stall_i) begin
            valid_q <= valid_q;
        end else if (load_use_hazard) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q     <= id_valid;
            ctrl_q      <= id_valid ? id_ctrl : '0;
            pc_q        <= id_pc;
            imm_q       <= id_imm;
            rd1_q       <= rd1_cap;
            rd2_q       <= rd2_cap;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            alu_ctrl_q  <= id_alu_control;
            src_a_pc_q  <= id_alu_src_a;
            src_b_imm_q <= id_alu_src_b;
        end
    end

    forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_forward_unit (
        .rs1           (rs1_q),
        .rs2           (rs2_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Resolve forwarded operand values from the selects.
    always_comb begin
        fwd_a_dat = rd1_q;
        fwd_b_dat = rd2_q;
        case (fwd_a)
            FWD_MEM: fwd_a_dat = mem_result;
            FWD_WB:  fwd_a_dat = wb_result;
            default: fwd_a_dat = rd1_q;
        endcase
        case (fwd_b)
            FWD_MEM: fwd_b_dat = mem_result;
            FWD_WB:  fwd_b_dat = wb_result;
            default: fwd_b_dat = rd2_q;
        endcase
    end

    assign SrcA          = src_a_pc_q  ? pc_q  : fwd_a_dat;
    assign SrcB          = src_b_imm_q ? imm_q : fwd_b_dat;
    assign ex_store_data = fwd_b_dat;
    assign ALUControl    = alu_ctrl_q;
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_rd         = rd_q;

    // A dead slot must never write the regfile or memory.
    assign ex_reg_write  = valid_q & ctrl_q.reg_write;
    assign ex_mem_read   = valid_q & ctrl_q.mem_read;
    assign ex_mem_write  = valid_q & ctrl_q.mem_write;
    assign ex_branch     = valid_q & ctrl_q.branch;
    assign ex_jump       = valid_q & ctrl_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding, load-use, stall/flush, WB bypass, async reset.
// Latency: checks EX outputs one cycle after each capture edge.
// Backpressure: drives stall_i/flush_i directly; no DUT-event waits.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic        id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_control;
    logic        id_alu_src_a, id_alu_src_b;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        load_use_hazard, ex_valid;
    logic [31:0] SrcA, SrcB, ex_store_data, ex_pc, ex_imm;
    logic [3:0]  ALUControl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
        .ALUControl(ALUControl), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put a decoded instruction on the ID inputs; control bits all cleared.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [3:0] alu, input logic src_b_imm);
        id_valid = 1'b1; id_pc = 32'h0000_1000 + {27'd0, rd} * 4;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_alu_control = alu; id_alu_src_a = 1'b0; id_alu_src_b = src_b_imm;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_branch = 1'b0; id_jump = 1'b0;
    endtask

    task automatic quiet_fwd();
        mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        issue(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0);
        id_valid = 1'b0;
        quiet_fwd();
        #12;
        check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst SrcA", SrcA, 32'd0);
        check("rst ALUControl", {28'd0, ALUControl}, 32'd0);
        check("rst ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        rst_n = 1'b1;
        tick();

        // add x3,x1,x2
        issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, ALU_ADD, 1'b0);
        id_reg_write = 1'b1;
        tick();
        check("add SrcA", SrcA, 32'd5);
        check("add SrcB", SrcB, 32'd7);
        check("add ALUControl", {28'd0, ALUControl}, 32'd0);
        check("add ex_valid", {31'd0, ex_valid}, 32'd1);
        check("add ex_rd", {27'd0, ex_rd}, 32'd3);
        check("add ex_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // Forwarding priority on the registered rs1=x1 / rs2=x2.
        id_valid = 1'b0;
        mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'h10;
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_result = 32'h20;
        #1 check("fwd mem beats wb", SrcA, 32'h10);
        mem_rd = 5'd0;
        #1 check("fwd wb when mem_rd=0", SrcA, 32'h20);
        wb_rd = 5'd0;
        #1 check("fwd x0 never", SrcA, 32'd5);
        mem_rd = 5'd2;
        #1 check("fwd mem to B", SrcB, 32'h10);
        check("store_data fwd", ex_store_data, 32'h10);
        quiet_fwd();
        tick();
        check("idle slot invalid", {31'd0, ex_valid}, 32'd0);

        // lw x5,4(x1) then dependent add x6,x5,x0
        issue(5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'd4, ALU_ADD, 1'b1);
        id_reg_write = 1'b1; id_mem_read = 1'b1;
        tick();
        check("lw ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        check("lw SrcA", SrcA, 32'h100);
        check("lw SrcB imm", SrcB, 32'd4);
        issue(5'd5, 5'd0, 5'd6, 32'h55, 32'h0, 32'h0, ALU_ADD, 1'b0);
        id_reg_write = 1'b1;
        #1 check("hazard asserted", {31'd0, load_use_hazard}, 32'd1);
        tick();
        check("bubble ex_valid", {31'd0, ex_valid}, 32'd0);
        check("bubble ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("hazard cleared", {31'd0, load_use_hazard}, 32'd0);
        tick();
        check("reissue ex_valid", {31'd0, ex_valid}, 32'd1);
        check("reissue ex_rd", {27'd0, ex_rd}, 32'd6);
        check("reissue SrcA", SrcA, 32'h55);

        // Stall three cycles with changing decode inputs.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(5'd9, 5'd10, 5'(11 + i), 32'(i + 77), 32'h9, 32'h3, ALU_SUB, 1'b1);
            id_mem_write = 1'b1;
            tick();
            check("stall ex_rd", {27'd0, ex_rd}, 32'd6);
            check("stall SrcA", SrcA, 32'h55);
            check("stall ALUControl", {28'd0, ALUControl}, 32'd0);
            check("stall ex_valid", {31'd0, ex_valid}, 32'd1);
        end
        stall_i = 1'b0;

        // sw x2,8(x1), then flush while stalled.
        issue(5'd1, 5'd2, 5'd0, 32'h200, 32'h33, 32'd8, ALU_ADD, 1'b1);
        id_mem_write = 1'b1;
        tick();
        check("sw ex_mem_write", {31'd0, ex_mem_write}, 32'd1);
        check("sw store_data", ex_store_data, 32'h33);
        check("sw SrcB imm", SrcB, 32'd8);
        stall_i = 1'b1; flush_i = 1'b1;
        tick();
        check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
        stall_i = 1'b0; flush_i = 1'b0;

        // Stall beats hazard; flush together with hazard gives a bubble.
        issue(5'd1, 5'd0, 5'd7, 32'h0, 32'h0, 32'd0, ALU_ADD, 1'b1);
        id_reg_write = 1'b1; id_mem_read = 1'b1;
        tick();
        issue(5'd3, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, ALU_OR, 1'b0);
        stall_i = 1'b1;
        tick();
        check("stall over hazard valid", {31'd0, ex_valid}, 32'd1);
        check("stall over hazard rd", {27'd0, ex_rd}, 32'd7);
        check("hazard via rs2", {31'd0, load_use_hazard}, 32'd1);
        stall_i = 1'b0; flush_i = 1'b1;
        #1 check("hazard under flush", {31'd0, load_use_hazard}, 32'd1);
        tick();
        check("flush+hazard bubble", {31'd0, ex_valid}, 32'd0);
        check("flush+hazard mem_read", {31'd0, ex_mem_read}, 32'd0);
        flush_i = 1'b0;

        // WB capture bypass; WB port is quiet afterwards so only the captured value can show.
        issue(5'd0, 5'd4, 5'd9, 32'h0, 32'h0, 32'h0, ALU_XOR, 1'b0);
        wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'hDEAD;
        tick();
        quiet_fwd();
        #1 check("wb capture SrcB", SrcB, 32'hDEAD);
        check("wb capture ALUControl", {28'd0, ALUControl}, {28'd0, ALU_XOR});

        // Asynchronous reset mid-cycle.
        issue(5'd1, 5'd2, 5'd10, 32'h1234, 32'h5678, 32'h0, ALU_SUB, 1'b0);
        id_reg_write = 1'b1; id_jump = 1'b1;
        tick();
        check("pre-reset ex_jump", {31'd0, ex_jump}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst ex_valid", {31'd0, ex_valid}, 32'd0);
        check("arst SrcA", SrcA, 32'd0);
        check("arst SrcB", SrcB, 32'd0);
        check("arst ALUControl", {28'd0, ALUControl}, 32'd0);
        check("arst ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("arst ex_jump", {31'd0, ex_jump}, 32'd0);
        check("arst ex_rd", {27'd0, ex_rd}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
